// File: rtl/life_arena_engine.sv
// Double-banked Conway arena: combinational read port for the renderer, one-cell-per-cycle
// generation scan into the back bank, atomic bank swap, and single-cell edit/clear in IDLE.
module life_arena_engine #(
    parameter int ARENA_WIDTH  = 10,
    parameter int ARENA_HEIGHT = 10,
    parameter int WRAP         = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  arena_row_select,
    input  logic [9:0]  arena_column_select,
    output logic        arena_cell_value,
    input  logic        step_request,
    output logic        step_busy,
    output logic        step_done,
    output logic [15:0] generation,
    input  logic        wr_en,
    input  logic [9:0]  wr_row,
    input  logic [9:0]  wr_col,
    input  logic        wr_value,
    input  logic        clear
);

    localparam int RW = (ARENA_HEIGHT > 1) ? $clog2(ARENA_HEIGHT) : 1;
    localparam int CW = (ARENA_WIDTH  > 1) ? $clog2(ARENA_WIDTH)  : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(ARENA_HEIGHT - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(ARENA_WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_SWAP} state_t;
    typedef logic [ARENA_HEIGHT-1:0][ARENA_WIDTH-1:0] bank_t;

    state_t        state_q, state_d;
    bank_t         bank_q [2];
    bank_t         front;
    logic          front_sel_q;
    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic [15:0]   gen_q;
    logic          done_q;

    logic          rd_ok, wr_ok, last_cell, new_cell;
    logic [RW-1:0] nr [3];
    logic [CW-1:0] nc [3];
    logic [2:0]    nr_ok, nc_ok;
    logic [3:0]    nbr_cnt;

    assign front = bank_q[front_sel_q];

    // Read port: the front bank only changes at IDLE edits and the SWAP edge, never mid-scan.
    assign rd_ok = (32'(arena_row_select) < ARENA_HEIGHT) &&
                   (32'(arena_column_select) < ARENA_WIDTH);
    assign arena_cell_value = rd_ok ?
        front[RW'(arena_row_select)][CW'(arena_column_select)] : 1'b0;

    assign wr_ok = (32'(wr_row) < ARENA_HEIGHT) && (32'(wr_col) < ARENA_WIDTH);
    assign last_cell = (row_q == ROW_LAST) && (col_q == COL_LAST);

    // Neighbour rows/cols with wrap; the _ok flags mask off-arena neighbours when WRAP=0.
    always_comb begin
        nr[1]    = row_q;
        nr[0]    = (row_q == '0) ? ROW_LAST : row_q - RW'(1);
        nr[2]    = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
        nr_ok[1] = 1'b1;
        nr_ok[0] = (WRAP != 0) || (row_q != '0);
        nr_ok[2] = (WRAP != 0) || (row_q != ROW_LAST);
        nc[1]    = col_q;
        nc[0]    = (col_q == '0) ? COL_LAST : col_q - CW'(1);
        nc[2]    = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
        nc_ok[1] = 1'b1;
        nc_ok[0] = (WRAP != 0) || (col_q != '0);
        nc_ok[2] = (WRAP != 0) || (col_q != COL_LAST);
    end

    always_comb begin
        nbr_cnt = '0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                if (!(dr == 1 && dc == 1)) begin
                    nbr_cnt = nbr_cnt +
                        {3'b000, nr_ok[dr] & nc_ok[dc] & front[nr[dr]][nc[dc]]};
                end
            end
        end
        new_cell = (nbr_cnt == 4'd3) | (front[row_q][col_q] & (nbr_cnt == 4'd2));
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (step_request) state_d = S_COMPUTE;
            S_COMPUTE: if (last_cell)    state_d = S_SWAP;
            S_SWAP:                      state_d = S_IDLE;
            default:                     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        step_busy  = (state_q != S_IDLE);
        step_done  = done_q;
        generation = gen_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_q[0]   <= '0;
            bank_q[1]   <= '0;
            front_sel_q <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            gen_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= (state_q == S_SWAP);
            case (state_q)
                S_IDLE: begin
                    // Edits land on the same edge a step is accepted, so the scan sees them.
                    if (clear) begin
                        bank_q[front_sel_q] <= '0;
                        gen_q               <= '0;
                    end else if (wr_en && wr_ok) begin
                        bank_q[front_sel_q][RW'(wr_row)][CW'(wr_col)] <= wr_value;
                    end
                    row_q <= '0;
                    col_q <= '0;
                end
                S_COMPUTE: begin
                    bank_q[~front_sel_q][row_q][col_q] <= new_cell;
                    if (col_q == COL_LAST) begin
                        col_q <= '0;
                        row_q <= row_q + RW'(1);
                    end else begin
                        col_q <= col_q + CW'(1);
                    end
                end
                S_SWAP: begin
                    front_sel_q <= ~front_sel_q;
                    gen_q       <= gen_q + 16'd1;
                    row_q       <= '0;
                    col_q       <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_life_arena_engine.sv
// Bench for life_arena_engine: a WRAP=0 and a WRAP=1 instance share stimulus and are checked
// against an array-based Life model plus constant tables for the classic patterns.
module tb_life_arena_engine;
    localparam int W = 10;
    localparam int H = 10;

    logic        clk = 1'b0;
    logic        reset, step_request, wr_en, wr_value, clear;
    logic [9:0]  rsel, csel, wr_row, wr_col;
    logic        cell0, cell1, busy0, busy1, done0, done1;
    logic [15:0] gen0, gen1;

    life_arena_engine #(.ARENA_WIDTH(W), .ARENA_HEIGHT(H), .WRAP(0)) dut0 (
        .clk(clk), .reset(reset), .arena_row_select(rsel), .arena_column_select(csel),
        .arena_cell_value(cell0), .step_request(step_request), .step_busy(busy0),
        .step_done(done0), .generation(gen0), .wr_en(wr_en), .wr_row(wr_row),
        .wr_col(wr_col), .wr_value(wr_value), .clear(clear));

    life_arena_engine #(.ARENA_WIDTH(W), .ARENA_HEIGHT(H), .WRAP(1)) dut1 (
        .clk(clk), .reset(reset), .arena_row_select(rsel), .arena_column_select(csel),
        .arena_cell_value(cell1), .step_request(step_request), .step_busy(busy1),
        .step_done(done1), .generation(gen1), .wr_en(wr_en), .wr_row(wr_row),
        .wr_col(wr_col), .wr_value(wr_value), .clear(clear));

    always #500 clk = ~clk;

    typedef struct {
        int phase;
        int inst;   // 0, 1, or 2 = both instances
        int row;
        int col;
        bit expv;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   passes = 0;
    bit   m [2][H][W];
    int   mgen = 0;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act == expv) passes++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mclear();
        for (int i = 0; i < 2; i++)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++) m[i][r][c] = 1'b0;
        mgen = 0;
    endtask

    task automatic mwrite(input int r, input int c, input bit v);
        if (r < H && c < W) begin
            m[0][r][c] = v;
            m[1][r][c] = v;
        end
    endtask

    // Conway rule from the definition: count live neighbours, wrap or drop off-arena ones.
    task automatic mstep();
        bit nx [H][W];
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < H; r++) begin
                for (int c = 0; c < W; c++) begin
                    int n = 0;
                    for (int dr = -1; dr <= 1; dr++) begin
                        for (int dc = -1; dc <= 1; dc++) begin
                            int rr = r + dr;
                            int cc = c + dc;
                            if (dr == 0 && dc == 0) continue;
                            if (i == 1) begin
                                rr = (rr + H) % H;
                                cc = (cc + W) % W;
                            end else if (rr < 0 || rr >= H || cc < 0 || cc >= W) continue;
                            n += int'(m[i][rr][cc]);
                        end
                    end
                    nx[r][c] = (n == 3) || (m[i][r][c] && n == 2);
                end
            end
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++) m[i][r][c] = nx[r][c];
        end
        mgen = (mgen + 1) % 65536;
    endtask

    task automatic check_arena(input string nm);
        int bad [2];
        string where [2];
        bad[0] = 0; bad[1] = 0;
        where[0] = "-"; where[1] = "-";
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                rsel = 10'(r);
                csel = 10'(c);
                #1;
                if (cell0 != m[0][r][c]) begin
                    if (bad[0] == 0) where[0] = $sformatf("(%0d,%0d)", r, c);
                    bad[0]++;
                end
                if (cell1 != m[1][r][c]) begin
                    if (bad[1] == 0) where[1] = $sformatf("(%0d,%0d)", r, c);
                    bad[1]++;
                end
            end
        end
        chk($sformatf("%s wrap0 bad cells first=%s", nm, where[0]), bad[0], 0);
        chk($sformatf("%s wrap1 bad cells first=%s", nm, where[1]), bad[1], 0);
    endtask

    task automatic run_phase(input int p);
        foreach (tbl[j]) begin
            if (tbl[j].phase != p) continue;
            rsel = 10'(tbl[j].row);
            csel = 10'(tbl[j].col);
            #1;
            if (tbl[j].inst != 1)
                chk($sformatf("ph%0d wrap0 (%0d,%0d)", p, tbl[j].row, tbl[j].col),
                    int'(cell0), int'(tbl[j].expv));
            if (tbl[j].inst != 0)
                chk($sformatf("ph%0d wrap1 (%0d,%0d)", p, tbl[j].row, tbl[j].col),
                    int'(cell1), int'(tbl[j].expv));
        end
    endtask

    task automatic wr(input int r, input int c, input bit v);
        wr_row = 10'(r); wr_col = 10'(c); wr_value = v; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        mwrite(r, c, v);
    endtask

    task automatic clr();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        mclear();
    endtask

    // Caller sets up any same-edge wr_en/clear (and its model effect) before calling.
    task automatic do_step(input bit poke);
        int k = 0;
        step_request = 1'b1;
        tick();
        step_request = 1'b0; wr_en = 1'b0; clear = 1'b0;
        chk("busy after request", int'(busy0 & busy1), 1);
        while (!done0 && k < 300) begin
            if (poke && k == 10) begin
                step_request = 1'b1; clear = 1'b1; wr_en = 1'b1;
                wr_row = 10'd0; wr_col = 10'd0; wr_value = 1'b1;
            end
            if (poke && k == 11) begin
                step_request = 1'b0; clear = 1'b0; wr_en = 1'b0;
            end
            tick();
            k++;
            if (poke && k == 50) begin
                chk("busy mid compute", int'(busy0), 1);
                check_arena("front stable during compute");
            end
        end
        chk("step_done cycle after request edge", k + 1, W * H + 2);
        chk("busy low at done", int'(busy0 | busy1), 0);
        chk("done on wrap1", int'(done1), 1);
        mstep();
        chk("generation wrap0", int'(gen0), mgen);
        chk("generation wrap1", int'(gen1), mgen);
        check_arena("after step");
        tick();
        chk("done single pulse / no queued step", int'(done0 | done1 | busy0 | busy1), 0);
    endtask

    initial begin
        int dcount;
        // phase 1: blinker after one step; also out-of-range reads
        tbl.push_back('{1, 2, 3, 4, 1'b1});
        tbl.push_back('{1, 2, 4, 4, 1'b1});
        tbl.push_back('{1, 2, 5, 4, 1'b1});
        tbl.push_back('{1, 2, 4, 3, 1'b0});
        tbl.push_back('{1, 2, 4, 5, 1'b0});
        tbl.push_back('{1, 2, 10, 4, 1'b0});
        tbl.push_back('{1, 2, 4, 200, 1'b0});
        tbl.push_back('{1, 2, 1023, 1023, 1'b0});
        // phase 2: blinker back to horizontal
        tbl.push_back('{2, 2, 4, 3, 1'b1});
        tbl.push_back('{2, 2, 4, 4, 1'b1});
        tbl.push_back('{2, 2, 4, 5, 1'b1});
        tbl.push_back('{2, 2, 3, 4, 1'b0});
        tbl.push_back('{2, 2, 5, 4, 1'b0});
        // phase 3: torus glider shifted (+1,+1); flat arena keeps corner dead
        tbl.push_back('{3, 1, 8, 9, 1'b1});
        tbl.push_back('{3, 1, 9, 0, 1'b1});
        tbl.push_back('{3, 1, 0, 8, 1'b1});
        tbl.push_back('{3, 1, 0, 9, 1'b1});
        tbl.push_back('{3, 1, 0, 0, 1'b1});
        tbl.push_back('{3, 1, 9, 9, 1'b0});
        tbl.push_back('{3, 1, 7, 8, 1'b0});
        tbl.push_back('{3, 0, 0, 0, 1'b0});
        // phase 4: still-life block
        tbl.push_back('{4, 2, 1, 1, 1'b1});
        tbl.push_back('{4, 2, 1, 2, 1'b1});
        tbl.push_back('{4, 2, 2, 1, 1'b1});
        tbl.push_back('{4, 2, 2, 2, 1'b1});
        tbl.push_back('{4, 2, 0, 0, 1'b0});
        tbl.push_back('{4, 2, 3, 3, 1'b0});

        reset = 1'b1; step_request = 1'b0; wr_en = 1'b0; clear = 1'b0;
        wr_value = 1'b0; wr_row = '0; wr_col = '0; rsel = '0; csel = '0;
        mclear();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("reset busy", int'(busy0 | busy1), 0);
        chk("reset done", int'(done0 | done1), 0);
        chk("reset generation", int'(gen0) + int'(gen1), 0);
        check_arena("reset");

        wr(4, 3, 1'b1); wr(4, 4, 1'b1); wr(4, 5, 1'b1);
        do_step(1'b0);
        run_phase(1);
        do_step(1'b1);
        run_phase(2);
        chk("blinker generation", int'(gen0), 2);

        clr();
        chk("clear zeroes generation", int'(gen0), 0);
        wr(1, 1, 1'b1); wr(1, 2, 1'b1); wr(2, 1, 1'b1); wr(2, 2, 1'b1);
        repeat (3) do_step(1'b0);
        run_phase(4);

        clr();
        wr(7, 8, 1'b1); wr(8, 9, 1'b1); wr(9, 7, 1'b1); wr(9, 8, 1'b1); wr(9, 9, 1'b1);
        repeat (4) do_step(1'b0);
        run_phase(3);

        // clear and write on the same edge: clear wins
        wr(3, 3, 1'b1); wr(6, 2, 1'b1);
        clear = 1'b1; wr_en = 1'b1; wr_row = 10'd5; wr_col = 10'd5; wr_value = 1'b1;
        tick();
        clear = 1'b0; wr_en = 1'b0;
        mclear();
        check_arena("clear beats write");

        // step with a same-edge write: the write is part of the generation
        wr(4, 3, 1'b1); wr(4, 4, 1'b1);
        wr_en = 1'b1; wr_row = 10'd4; wr_col = 10'd5; wr_value = 1'b1;
        mwrite(4, 5, 1'b1);
        do_step(1'b0);

        // step with a same-edge clear: computed from an empty arena
        clear = 1'b1;
        mclear();
        do_step(1'b0);

        for (int rnd = 0; rnd < 8; rnd++) begin
            int nw = int'($urandom_range(10, 40));
            if ($urandom_range(0, 3) == 0) clr();
            for (int j = 0; j < nw; j++) begin
                int r = ($urandom_range(0, 9) == 0) ? 1023 : int'($urandom_range(0, 10));
                int c = ($urandom_range(0, 9) == 0) ? 200 : int'($urandom_range(0, 10));
                wr(r, c, 1'($urandom_range(0, 1)));
            end
            do_step(1'b0);
            if (rnd % 2 == 1) do_step(1'b0);
        end

        // reset in the middle of a scan
        wr(2, 2, 1'b1);
        step_request = 1'b1;
        tick();
        step_request = 1'b0;
        repeat (49) tick();
        chk("busy before abort", int'(busy0), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("busy after abort", int'(busy0 | busy1), 0);
        dcount = 0;
        repeat (120) begin
            tick();
            if (done0 | done1) dcount++;
        end
        chk("no done after abort", dcount, 0);
        mclear();
        chk("generation after abort", int'(gen0) + int'(gen1), 0);
        check_arena("arena after abort");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
